hazard_ctrl: RTL and testbench

//  Produces the stall/flush controls consumed by the pipeBuffer stage registers
//  (PC, IF/ID, ID/EX, EX/MEM) of the 5-stage core.

---
 rtl/hazard_pkg.sv | 60 ++++++
 rtl/hazard_ctrl_if.sv | 45 ++++
 rtl/hazard_ctrl_checker.sv | 34 +++
 rtl/sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 6 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the pipeline hazard controller.
//   - md_state_t  : mul/div sequencing states
//   - pipe_ctrl_t : stall/flush bundle for the PC, IF/ID, ID/EX, EX/MEM buffers
//   - REG_ZERO    : the hard-wired zero register, which never creates a hazard
//   - ctrl* helpers : canonical stall/flush patterns for each hazard response
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic stallPC;
    logic stallIFID;
    logic flushIFID;
    logic stallIDEX;
    logic flushIDEX;
    logic flushEXMEM;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Taken branch: squash the two wrong-path instructions behind EX.
  function automatic pipe_ctrl_t ctrlBranch();
    pipe_ctrl_t c;
    c = CTRL_NONE;
    c.flushIFID = 1'b1;
    c.flushIDEX = 1'b1;
    return c;
  endfunction

  // Mul/div in EX: freeze everything upstream, feed bubbles into MEM.
  function automatic pipe_ctrl_t ctrlMdHold();
    pipe_ctrl_t c;
    c = CTRL_NONE;
    c.stallPC    = 1'b1;
    c.stallIFID  = 1'b1;
    c.stallIDEX  = 1'b1;
    c.flushEXMEM = 1'b1;
    return c;
  endfunction

  // Load-use: hold the consumer in ID and insert one bubble into EX.
  function automatic pipe_ctrl_t ctrlLoadUse();
    pipe_ctrl_t c;
    c = CTRL_NONE;
    c.stallPC   = 1'b1;
    c.stallIFID = 1'b1;
    c.flushIDEX = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard controller.
//   master : datapath side (drives ID/EX hazard info, receives controls)
//   slave  : hazard controller side
//   Inputs to controller : idRs, idRt, idUsesRt, exRd, exMemRead,
//                          exBranchTaken, exMdStart
//   Outputs of controller: stallPC, stallIFID, flushIFID, stallIDEX,
//                          flushIDEX, flushEXMEM, mdDone, stallCount
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 16
);

  logic [REG_ADDR-1:0] idRs;
  logic [REG_ADDR-1:0] idRt;
  logic                idUsesRt;
  logic [REG_ADDR-1:0] exRd;
  logic                exMemRead;
  logic                exBranchTaken;
  logic                exMdStart;

  logic                stallPC;
  logic                stallIFID;
  logic                flushIFID;
  logic                stallIDEX;
  logic                flushIDEX;
  logic                flushEXMEM;
  logic                mdDone;
  logic [CNT_W-1:0]    stallCount;

  modport master (
    output idRs, idRt, idUsesRt, exRd, exMemRead, exBranchTaken, exMdStart,
    input  stallPC, stallIFID, flushIFID, stallIDEX, flushIDEX, flushEXMEM,
           mdDone, stallCount
  );

  modport slave (
    input  idRs, idRt, idUsesRt, exRd, exMemRead, exBranchTaken, exMdStart,
    output stallPC, stallIFID, flushIFID, stallIDEX, flushIDEX, flushEXMEM,
           mdDone, stallCount
  );

endinterface

// File: rtl/hazard_ctrl_checker.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_checker
//   Protocol and consistency properties for hazard_ctrl.
//   clk, reset    : controller clock and active-low reset
//   state         : mul/div sequencing state
//   exBranchTaken : must not be raised while a mul/div occupies EX
//   exMemRead     : must not be raised while a mul/div occupies EX
//   stall*/flush* : a buffer never sees stall and flush together
// ---------------------------------------------------------------------------
module hazard_ctrl_checker
  import hazard_pkg::*;
(
  input logic      clk,
  input logic      reset,
  input md_state_t state,
  input logic      exBranchTaken,
  input logic      exMemRead,
  input logic      stallIFID,
  input logic      flushIFID,
  input logic      stallIDEX,
  input logic      flushIDEX
);

  // A branch or load cannot be in EX while the mul/div owns it.
  assert property (@(posedge clk) disable iff (!reset)
    (state != IDLE) |-> !(exBranchTaken || exMemRead))
    else $error("hazard_ctrl: branch/load seen in EX while mul/div busy");

  // The stage buffers ignore flush under stall, so never request both.
  assert property (@(posedge clk) disable iff (!reset)
    !(stallIFID && flushIFID) && !(stallIDEX && flushIDEX))
    else $error("hazard_ctrl: stall and flush raised on one buffer");

endmodule

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Enable-driven up-counter that sticks at its all-ones maximum.
//   clk   : clock, rising edge
//   reset : asynchronous active-low clear
//   en    : count this cycle
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counter register: increments when enabled, holds once saturated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {CNT_W{1'b0}};
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Stall/flush generator for the 5-stage core's stage buffers.
//   - load-use in ID vs load in EX -> one bubble per cycle it persists
//   - taken branch/jump in EX      -> squash IF/ID and ID/EX
//   - mul/div in EX                -> hold upstream for MD_LAT-1 cycles,
//                                     then a one-cycle mdDone
//   - saturating count of cycles with stallPC high
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous active-low reset; forces all outputs low at once
//     hz    : hazard_ctrl_if.slave (hazard inputs, stall/flush outputs,
//             mdDone, stallCount)
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR = 5,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  localparam int CW = $clog2(MD_LAT);

  md_state_t  state;
  md_state_t  stateNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic       loadUse;
  pipe_ctrl_t ctrl;
  logic       mdDoneC;

  // Load in EX feeding a source register of the instruction in ID.
  always_comb begin
    loadUse = 1'b0;
    if (hz.exMemRead && (hz.exRd != REG_ADDR'(REG_ZERO))) begin
      loadUse = (hz.exRd == hz.idRs) || (hz.idUsesRt && (hz.exRd == hz.idRt));
    end else begin
      loadUse = 1'b0;
    end
  end

  // FSM state register and mul/div occupancy down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= {CW{1'b0}};
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // FSM next state: the start cycle plus MD_LAT-3 counted cycles plus the
  // cnt==0 cycle give MD_LAT-1 stalled cycles before DONE.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        // A taken branch wins: the mul/div start is not launched.
        if (!hz.exBranchTaken && hz.exMdStart) begin
          stateNext = BUSY;
          cntNext   = CW'(MD_LAT - 3);
        end else begin
          stateNext = IDLE;
          cntNext   = cnt;
        end
      end
      BUSY: begin
        if (cnt == {CW{1'b0}}) begin
          stateNext = DONE;
          cntNext   = cnt;
        end else begin
          stateNext = BUSY;
          cntNext   = cnt - CW'(1);
        end
      end
      DONE: begin
        // exMdStart is still the finishing instruction here; ignore it.
        stateNext = IDLE;
        cntNext   = cnt;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = {CW{1'b0}};
      end
    endcase
  end

  // FSM outputs: combinational so the buffers react in the same cycle;
  // reset gating makes them drop without waiting for a clock.
  always_comb begin
    ctrl    = CTRL_NONE;
    mdDoneC = 1'b0;
    if (!reset) begin
      ctrl    = CTRL_NONE;
      mdDoneC = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hz.exBranchTaken) begin
            ctrl = ctrlBranch();
          end else if (hz.exMdStart) begin
            ctrl = ctrlMdHold();
          end else if (loadUse) begin
            ctrl = ctrlLoadUse();
          end else begin
            ctrl = CTRL_NONE;
          end
        end
        BUSY: begin
          // The full hold already covers any load-use or branch behind it.
          ctrl = ctrlMdHold();
        end
        DONE: begin
          mdDoneC = 1'b1;
        end
        default: begin
          ctrl    = CTRL_NONE;
          mdDoneC = 1'b0;
        end
      endcase
    end
  end

  assign hz.stallPC    = ctrl.stallPC;
  assign hz.stallIFID  = ctrl.stallIFID;
  assign hz.flushIFID  = ctrl.flushIFID;
  assign hz.stallIDEX  = ctrl.stallIDEX;
  assign hz.flushIDEX  = ctrl.flushIDEX;
  assign hz.flushEXMEM = ctrl.flushEXMEM;
  assign hz.mdDone     = mdDoneC;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stallCnt (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl.stallPC),
    .count (hz.stallCount)
  );

  hazard_ctrl_checker u_chk (
    .clk           (clk),
    .reset         (reset),
    .state         (state),
    .exBranchTaken (hz.exBranchTaken),
    .exMemRead     (hz.exMemRead),
    .stallIFID     (ctrl.stallIFID),
    .flushIFID     (ctrl.flushIFID),
    .stallIDEX     (ctrl.stallIDEX),
    .flushIDEX     (ctrl.flushIDEX)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Scoreboard bench for hazard_ctrl (MD_LAT=4, CNT_W=4). Each cycle the
//   expected output vector is pushed when inputs are driven and popped and
//   compared at the following falling edge.
//   Vector layout: [10] stallPC [9] stallIFID [8] flushIFID [7] stallIDEX
//                  [6] flushIDEX [5] flushEXMEM [4] mdDone [3:0] stallCount
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int REG_ADDR = 5;
  localparam int MD_LAT   = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  hazard_ctrl_if #(.REG_ADDR(REG_ADDR), .CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .REG_ADDR (REG_ADDR),
    .MD_LAT   (MD_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;
  logic [15:0] expQ[$];

  // reference model state
  int mStall = 0;   // remaining hold cycles after the current one
  bit mDone  = 1'b0;
  int mCount = 0;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] observed();
    return {5'd0, hz.stallPC, hz.stallIFID, hz.flushIFID, hz.stallIDEX,
            hz.flushIDEX, hz.flushEXMEM, hz.mdDone, hz.stallCount};
  endfunction

  function automatic logic [15:0] modelOut(input bit ld, input bit br, input bit md);
    logic [6:0] c;
    c = 7'b0000000;
    if (mDone)           c = 7'b0000001;
    else if (mStall > 0) c = 7'b1101010;
    else if (br)         c = 7'b0010100;
    else if (md)         c = 7'b1101010;
    else if (ld)         c = 7'b1100100;
    return {5'd0, c, 4'(mCount)};
  endfunction

  task automatic driveZero();
    hz.idRs = 5'd0; hz.idRt = 5'd0; hz.idUsesRt = 1'b0; hz.exRd = 5'd0;
    hz.exMemRead = 1'b0; hz.exBranchTaken = 1'b0; hz.exMdStart = 1'b0;
  endtask

  task automatic modelReset();
    mStall = 0; mDone = 1'b0; mCount = 0;
  endtask

  // One clock cycle of stimulus with scoreboarded expectation.
  task automatic cycle(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic usesRt, input logic [4:0] rd, input logic memRead,
                       input logic br, input logic md);
    logic [15:0] e;
    bit ld;
    @(posedge clk); #1;
    hz.idRs = rs; hz.idRt = rt; hz.idUsesRt = usesRt; hz.exRd = rd;
    hz.exMemRead = memRead; hz.exBranchTaken = br; hz.exMdStart = md;
    ld = memRead && (rd != 5'd0) && ((rd == rs) || (usesRt && (rd == rt)));
    expQ.push_back(modelOut(ld, br, md));
    @(negedge clk);
    if (expQ.size() == 0) begin
      nVec++; nErr++;
      $display("FAIL %s: scoreboard empty, got %h expected an entry", tag, observed());
      e = 16'd0;
    end else begin
      e = expQ.pop_front();
      checkVal(tag, observed(), e);
    end
    if (e[10] && (mCount < CNT_MAX)) mCount++;
    if (mDone) mDone = 1'b0;
    else if (mStall > 0) begin
      mStall--;
      if (mStall == 0) mDone = 1'b1;
    end else if (!br && md) mStall = MD_LAT - 2;
  endtask

  // Reset with hazardous inputs present: outputs must be low regardless.
  task automatic applyReset();
    @(posedge clk); #1;
    reset = 1'b0;
    hz.exMemRead = 1'b1; hz.exRd = 5'd8; hz.idRs = 5'd8; hz.exMdStart = 1'b1;
    #2 checkVal("rst_out", observed(), 16'd0);
    repeat (2) @(posedge clk);
    #1 checkVal("rst_hold", observed(), 16'd0);
    driveZero();
    #1 reset = 1'b1;
    modelReset();
  endtask

  initial begin
    reset = 1'b0;
    driveZero();
    modelReset();
    applyReset();

    // load-use on rs, then same with exRd = zero register
    cycle("lu_rs",   5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    cycle("lu_r0",   5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle("idle",    5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    // rt match only counts when the ID instruction reads rt
    cycle("rt_unused", 5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    cycle("rt_used",   5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    // branch overrides load-use; branch overrides mul/div; mul/div over load-use
    cycle("br_lu",   5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    cycle("br_md",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle("md_lu",   5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("md_lu_run", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("md_lu_after", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // single op: exMdStart held for its 4-cycle EX occupancy
    for (int i = 0; i < 4; i++) cycle("md_single", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("md_gap", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    // back-to-back ops: 3 stall + done + 3 stall + done
    for (int i = 0; i < 8; i++) cycle("md_b2b", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("md_b2b_end", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // reset dropped in the second BUSY cycle
    applyReset();
    cycle("md5_start", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("md5_busy1", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    hz.exMdStart = 1'b1;
    #1 reset = 1'b0;
    #1 checkVal("rst_midop", observed(), 16'd0);
    modelReset();
    @(posedge clk); #1;
    driveZero();
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst_nodone", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("post_rst_idle_lu", 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);

    // counter saturation
    applyReset();
    for (int i = 0; i < 20; i++) cycle("sat_lu", 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    cycle("sat_end", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkVal("sat_count", {12'd0, hz.stallCount}, 16'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
